// File: rtl/e603_icb_init_pkg.sv
// Shared status codes and one-hot FSM encoding for the ICB initiator.
package e603_icb_init_pkg;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ERR     = 2'b10;

  typedef enum logic [4:0] {
    StIdle = 5'b00001,
    StCmd  = 5'b00010,
    StRsp  = 5'b00100,
    StGap  = 5'b01000,
    StDone = 5'b10000
  } icb_init_state_e;

endpackage

// File: rtl/e603_icb_init_pollcnt.sv
// Poll bookkeeping: attempt counter, inter-poll gap down-counter and masked compare.
module e603_icb_init_pollcnt #(
  parameter int unsigned DW      = 32,
  parameter int unsigned RETRY_W = 16,
  parameter int unsigned GAP_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               retry_i,
  input  logic               gap_tick_i,
  input  logic [RETRY_W-1:0] max_retry_i,
  input  logic [GAP_W-1:0]   gap_i,
  input  logic [DW-1:0]      rdata_i,
  input  logic [DW-1:0]      mask_i,
  input  logic [DW-1:0]      expect_i,
  output logic               match_o,
  output logic               last_o,
  output logic               gap_end_o
);

  logic [RETRY_W-1:0] attempt_q, attempt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  always_comb begin
    attempt_d = attempt_q;
    gap_cnt_d = gap_cnt_q;
    if (clear_i) begin
      attempt_d = '0;
      gap_cnt_d = '0;
    end else if (retry_i) begin
      // Saturate so the counter can never wrap back to a fresh budget.
      if (attempt_q != '1) begin
        attempt_d = attempt_q + RETRY_W'(1);
      end
      gap_cnt_d = gap_i;
    end else if (gap_tick_i && (gap_cnt_q != '0)) begin
      gap_cnt_d = gap_cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      attempt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      attempt_q <= attempt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign match_o   = ((rdata_i & mask_i) == (expect_i & mask_i));
  assign last_o    = (attempt_q == max_retry_i);
  // Leaving at count 1 gives exactly gap_i idle cycles between attempts.
  assign gap_end_o = (gap_cnt_q == GAP_W'(1));

endmodule

// File: rtl/e603_subsys_icb_init.sv
// ICB initiator for write / read / poll-read host requests, one transaction outstanding.
// Optional E603_ICB_INIT_ERR_EN adds icb_rsp_err and the ERR completion status.
module e603_subsys_icb_init
  import e603_icb_init_pkg::*;
#(
  parameter int unsigned AW      = 12,
  parameter int unsigned DW      = 32,
  parameter int unsigned RETRY_W = 16,
  parameter int unsigned GAP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_read,
  input  logic               req_poll,
  input  logic [AW-1:0]      req_addr,
  input  logic [DW-1:0]      req_wdata,
  input  logic [DW-1:0]      req_mask,
  input  logic [DW-1:0]      req_expect,
  input  logic [RETRY_W-1:0] req_max_retry,
  input  logic [GAP_W-1:0]   req_gap,
  output logic               done_valid,
  input  logic               done_ready,
  output logic [DW-1:0]      done_rdata,
  output logic [1:0]         done_status,
  output logic               busy,
  output logic               icb_cmd_valid,
  input  logic               icb_cmd_ready,
  output logic [AW-1:0]      icb_cmd_addr,
  output logic               icb_cmd_read,
  output logic [DW-1:0]      icb_cmd_wdata,
  input  logic               icb_rsp_valid,
  output logic               icb_rsp_ready,
`ifdef E603_ICB_INIT_ERR_EN
  input  logic               icb_rsp_err,
`endif
  input  logic [DW-1:0]      icb_rsp_rdata
);

  icb_init_state_e state_q, state_d;

  logic [AW-1:0]      addr_q, addr_d;
  logic               read_q, read_d;
  logic               poll_q, poll_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [DW-1:0]      mask_q, mask_d;
  logic [DW-1:0]      expect_q, expect_d;
  logic [RETRY_W-1:0] max_retry_q, max_retry_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic [1:0]         status_q, status_d;

  logic cnt_clear, cnt_retry, gap_tick;
  logic match, last, gap_end;
  logic rsp_take, rsp_err;

`ifdef E603_ICB_INIT_ERR_EN
  assign rsp_err = icb_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign gap_tick = (state_q == StGap);

  e603_icb_init_pollcnt #(
    .DW      (DW),
    .RETRY_W (RETRY_W),
    .GAP_W   (GAP_W)
  ) u_pollcnt (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (cnt_clear),
    .retry_i     (cnt_retry),
    .gap_tick_i  (gap_tick),
    .max_retry_i (max_retry_q),
    .gap_i       (gap_q),
    .rdata_i     (icb_rsp_rdata),
    .mask_i      (mask_q),
    .expect_i    (expect_q),
    .match_o     (match),
    .last_o      (last),
    .gap_end_o   (gap_end)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    poll_d      = poll_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    expect_d    = expect_q;
    max_retry_d = max_retry_q;
    gap_d       = gap_q;
    rdata_d     = rdata_q;
    status_d    = status_q;
    cnt_clear   = 1'b0;
    cnt_retry   = 1'b0;
    rsp_take    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d      = req_addr;
          read_d      = req_poll | req_read;
          poll_d      = req_poll;
          wdata_d     = req_wdata;
          mask_d      = req_mask;
          expect_d    = req_expect;
          max_retry_d = req_max_retry;
          gap_d       = req_gap;
          cnt_clear   = 1'b1;
          state_d     = StCmd;
        end
      end
      StCmd: begin
        // A response without the command handshake is not ours; ignore it.
        if (icb_cmd_ready) begin
          state_d  = StRsp;
          rsp_take = icb_rsp_valid;
        end
      end
      StRsp: rsp_take = icb_rsp_valid;
      StGap: begin
        if (gap_end) begin
          state_d = StCmd;
        end
      end
      StDone: begin
        if (done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rsp_take) begin
      state_d  = StDone;
      rdata_d  = icb_rsp_rdata;
      status_d = ST_OK;
      if (rsp_err) begin
        status_d = ST_ERR;
      end else if (!read_q) begin
        rdata_d = '0;
      end else if (poll_q && !match) begin
        if (last) begin
          status_d = ST_TIMEOUT;
        end else begin
          cnt_retry = 1'b1;
          state_d   = (gap_q == '0) ? StCmd : StGap;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      read_q      <= 1'b0;
      poll_q      <= 1'b0;
      wdata_q     <= '0;
      mask_q      <= '0;
      expect_q    <= '0;
      max_retry_q <= '0;
      gap_q       <= '0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      poll_q      <= poll_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      expect_q    <= expect_d;
      max_retry_q <= max_retry_d;
      gap_q       <= gap_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
    end
  end

  // All handshake outputs decode straight from the registered one-hot state.
  assign req_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign icb_cmd_valid = (state_q == StCmd);
  assign icb_rsp_ready = (state_q == StCmd) || (state_q == StRsp);
  assign icb_cmd_addr  = addr_q;
  assign icb_cmd_read  = read_q;
  assign icb_cmd_wdata = wdata_q;
  assign done_valid    = (state_q == StDone);
  assign done_rdata    = rdata_q;
  assign done_status   = status_q;

endmodule
